// File: rtl/axi_lite_reg_bank.sv
// Register bank behind the AXI4-Lite slave strobe interface.
// Holds CTRL, STATUS, COMPARE and a free-running COUNT. It drives the LEDs,
// samples the switches, and raises a level interrupt on counter/compare match.
module axi_lite_reg_bank #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LED_WIDTH  = 8,
    parameter int SW_WIDTH   = 8
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic                    reg_wr_en,
    input  logic [ADDR_WIDTH-1:0]   reg_wr_addr,
    input  logic [DATA_WIDTH-1:0]   reg_wr_data,
    input  logic [DATA_WIDTH/8-1:0] reg_wr_strb,
    input  logic                    reg_rd_en,
    input  logic [ADDR_WIDTH-1:0]   reg_rd_addr,
    output logic [DATA_WIDTH-1:0]   reg_rd_data,
    output logic                    reg_rd_valid,
    input  logic [SW_WIDTH-1:0]     sw_in,
    output logic [LED_WIDTH-1:0]    led_out,
    output logic                    irq
);

    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_COMPARE = 2'd2;
    localparam logic [1:0] OFF_COUNT   = 2'd3;

    logic                  r_cnt_en;
    logic                  r_irq_en;
    logic [7:0]            r_led;
    logic [31:0]           r_compare;
    logic [31:0]           r_count;
    logic                  r_match;
    logic [SW_WIDTH-1:0]   r_sw_meta;
    logic [SW_WIDTH-1:0]   r_sw_sync;
    logic [31:0]           r_rd_data;
    logic                  r_rd_valid;
    logic                  r_irq;

    logic                  w_wr_ctrl;
    logic                  w_wr_compare;
    logic                  w_cnt_clr;
    logic                  w_w1c;
    logic                  w_match_hit;
    logic [7:0]            w_sw_ext;
    logic [31:0]           w_rd_mux;

    // Decode: byte address bits [1:0] are ignored, only the word select matters.
    assign w_wr_ctrl    = reg_wr_en && (reg_wr_addr[3:2] == OFF_CTRL);
    assign w_wr_compare = reg_wr_en && (reg_wr_addr[3:2] == OFF_COMPARE);
    assign w_cnt_clr    = w_wr_ctrl && reg_wr_strb[0] && reg_wr_data[1];
    assign w_w1c        = reg_wr_en && (reg_wr_addr[3:2] == OFF_STATUS)
                          && reg_wr_strb[0] && reg_wr_data[0];
    // Match uses the pre-increment count of this cycle.
    assign w_match_hit  = r_cnt_en && (r_count == r_compare);
    assign w_sw_ext     = 8'(r_sw_sync);

    // CTRL fields; cnt_clr is a pulse and is never stored.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_cnt_en <= 1'b0;
            r_irq_en <= 1'b0;
            r_led    <= 8'h00;
        end else if (w_wr_ctrl) begin
            if (reg_wr_strb[0]) begin
                r_cnt_en <= reg_wr_data[0];
                r_irq_en <= reg_wr_data[2];
            end
            if (reg_wr_strb[1]) begin
                r_led <= reg_wr_data[15:8];
            end
        end
    end

    // COMPARE register with per-byte-lane writes.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_compare <= 32'hFFFF_FFFF;
        end else if (w_wr_compare) begin
            for (int i = 0; i < 4; i++) begin
                if (reg_wr_strb[i]) begin
                    r_compare[8*i +: 8] <= reg_wr_data[8*i +: 8];
                end
            end
        end
    end

    // Free-running counter; a clear request wins over the increment.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_count <= 32'h0;
        end else if (w_cnt_clr) begin
            r_count <= 32'h0;
        end else if (r_cnt_en) begin
            r_count <= r_count + 32'd1;
        end
    end

    // Sticky match flag; a new match wins over a simultaneous W1C clear.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_match <= 1'b0;
        end else if (w_match_hit) begin
            r_match <= 1'b1;
        end else if (w_w1c) begin
            r_match <= 1'b0;
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Read mux over current register state, so a read sees pre-update values.
    always_comb begin
        w_rd_mux = 32'h0;
        case (reg_rd_addr[3:2])
            OFF_CTRL:    w_rd_mux = {16'h0, r_led, 5'b0, r_irq_en, 1'b0, r_cnt_en};
            OFF_STATUS:  w_rd_mux = {16'h0, w_sw_ext, 6'b0, r_cnt_en, r_match};
            OFF_COMPARE: w_rd_mux = r_compare;
            OFF_COUNT:   w_rd_mux = r_count;
            default:     w_rd_mux = 32'h0;
        endcase
    end

    // Read response: data captured on the strobe, held until the next read.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rd_data  <= 32'h0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= reg_rd_en;
            if (reg_rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    // Registered interrupt, one cycle behind the visible flag.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_match & r_irq_en;
        end
    end

    assign reg_rd_data  = DATA_WIDTH'(r_rd_data);
    assign reg_rd_valid = r_rd_valid;
    assign led_out      = r_led[LED_WIDTH-1:0];
    assign irq          = r_irq;

endmodule
